microwave_controller: RTL

- Top-level sequencer for the countdown `timer` (min / sec_tens / sec_ones, digit-shift load, `zero` flag).
- Accepts keypad digits and start/stop/door events, then drives the timer's `data`, `loadn`, `clearn` and `enable` pins.
- Generates the one-second countdown strobe, controls the magnetron and flags cycle completion.
- Sits between the keypad/door front-end and the timer; the display reads the timer outputs directly.

---
 rtl/microwave_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/microwave_controller.sv
// microwave_controller: keypad/door sequencer driving the countdown timer's data/loadn/clearn/enable pins.
// Optional feature macro MICROWAVE_QUICK_START_EN: start on an empty timer loads 0:30 (QLOAD) and cooks.
module microwave_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_DIGITS  = 3,
    parameter int DONE_CYCLES = 100
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_clearn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ENTRY = 3'd1;
    localparam logic [2:0] COOK  = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
`ifdef MICROWAVE_QUICK_START_EN
    localparam logic [2:0] QLOAD = 3'd5;
`endif

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DIG_W  = $clog2(MAX_DIGITS + 1);
    localparam int DONE_W = $clog2(DONE_CYCLES + 1);

    logic [2:0]        state_q,   state_d;
    logic [DIG_W-1:0]  digits_q,  digits_d;
    logic [TICK_W-1:0] tick_q,    tick_d;
    logic [DONE_W-1:0] doneCnt_q, doneCnt_d;
    logic [3:0]        data_q,    data_d;
    logic              loadn_q,   loadn_d;
    logic              clearn_q,  clearn_d;
    logic              enable_q,  enable_d;
    logic              mag_q,     mag_d;
    logic              done_q,    done_d;
    logic              validKey;
`ifdef MICROWAVE_QUICK_START_EN
    logic [1:0]        qIdx_q,    qIdx_d;
`endif

    // A keypad digit is only accepted while there is room left in the entry sequence.
    assign validKey = key_valid && (key_digit <= 4'd9) && (digits_q < DIG_W'(MAX_DIGITS));

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        tick_d    = '0;
        doneCnt_d = '0;
        data_d    = data_q;
        loadn_d   = 1'b1;
        clearn_d  = 1'b1;
        enable_d  = 1'b0;
`ifdef MICROWAVE_QUICK_START_EN
        qIdx_d    = qIdx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (door_closed && !timer_zero) begin
                        state_d = COOK;
`ifdef MICROWAVE_QUICK_START_EN
                    end else if (door_closed) begin
                        state_d = QLOAD;
                        loadn_d = 1'b0;
                        data_d  = 4'd0;
                        qIdx_d  = 2'd1;
`endif
                    end
                end else if (validKey) begin
                    state_d  = ENTRY;
                    loadn_d  = 1'b0;
                    data_d   = key_digit;
                    digits_d = digits_q + 1'b1;
                end
            end
            ENTRY: begin
                if (stop) begin
                    state_d  = IDLE;
                    clearn_d = 1'b0;
                    digits_d = '0;
                end else if (start) begin
                    if (door_closed && !timer_zero) state_d = COOK;
                end else if (validKey) begin
                    loadn_d  = 1'b0;
                    data_d   = key_digit;
                    digits_d = digits_q + 1'b1;
                end
            end
            COOK: begin
                if (timer_zero) begin
                    state_d = DONE;
                end else if (!door_closed || stop) begin
                    state_d = PAUSE;
                end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                    enable_d = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d  = IDLE;
                    clearn_d = 1'b0;
                    digits_d = '0;
                end else if (start && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (stop || !door_closed || (doneCnt_q == DONE_W'(DONE_CYCLES - 1))) begin
                    state_d  = IDLE;
                    digits_d = '0;
                end else begin
                    doneCnt_d = doneCnt_q + 1'b1;
                end
            end
`ifdef MICROWAVE_QUICK_START_EN
            // Digits 0,3,0 are shifted in on consecutive cycles, then cooking starts at 0:30.
            QLOAD: begin
                if (stop || !door_closed) begin
                    state_d  = IDLE;
                    clearn_d = 1'b0;
                    digits_d = '0;
                end else if (qIdx_q == 2'd3) begin
                    state_d = COOK;
                end else begin
                    loadn_d = 1'b0;
                    data_d  = (qIdx_q == 2'd1) ? 4'd3 : 4'd0;
                    qIdx_d  = qIdx_q + 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        mag_d  = (state_d == COOK);
        done_d = (state_d == DONE);
    end

    // clearn sits low during reset so the timer is cleared together with the controller.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            tick_q    <= '0;
            doneCnt_q <= '0;
            data_q    <= 4'd0;
            loadn_q   <= 1'b1;
            clearn_q  <= 1'b0;
            enable_q  <= 1'b0;
            mag_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef MICROWAVE_QUICK_START_EN
            qIdx_q    <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            tick_q    <= tick_d;
            doneCnt_q <= doneCnt_d;
            data_q    <= data_d;
            loadn_q   <= loadn_d;
            clearn_q  <= clearn_d;
            enable_q  <= enable_d;
            mag_q     <= mag_d;
            done_q    <= done_d;
`ifdef MICROWAVE_QUICK_START_EN
            qIdx_q    <= qIdx_d;
`endif
        end
    end

    assign timer_data   = data_q;
    assign timer_loadn  = loadn_q;
    assign timer_clearn = clearn_q;
    assign timer_enable = enable_q;
    assign mag_on       = mag_q;
    assign done         = done_q;
    assign state_o      = state_q;

endmodule
